// File: rtl/divider_nr_param.sv
// divider_nr_param: multi-cycle non-restoring integer divider, signed or unsigned.
// A start edge loads the operand magnitudes. WIDTH iterations follow, one per cycle.
// A fix-up cycle then restores the remainder and applies the signs.
// data_resultRDY rises WIDTH+2 edges after the start edge.
// A zero divisor short-circuits to an exception after one edge.
// Optional feature: define DIVIDER_REMAINDER_EN to add the data_remainder port and its
// sign-correction logic; without it only the quotient and exception flag are produced.

module divider_nr_param #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
`ifdef DIVIDER_REMAINDER_EN
   output logic [WIDTH-1:0] data_remainder,
`endif
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t state;
   state_t state_next;

   // partial remainder is one bit wider so |MIN| and large unsigned divisors never overflow
   logic [WIDTH:0]   p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] b_mag;
   logic [CW-1:0]    count;
   logic             sign_q;
   logic             div_zero;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   p_step;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] q_final;

`ifdef DIVIDER_REMAINDER_EN
   logic [WIDTH-1:0] a_cap;
   logic             sign_r;
   logic [WIDTH-1:0] p_fixed;
   logic [WIDTH-1:0] r_final;
`endif

   // operand magnitudes, one non-restoring step and the quotient sign fix-up
   always_comb begin
      a_mag   = (is_signed && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
      b_abs   = (is_signed && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;
      b_ext   = {1'b0, b_mag};
      p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
      p_step  = p[WIDTH] ? (p_shift + b_ext) : (p_shift - b_ext);
      q_step  = {q[WIDTH-2:0], ~p_step[WIDTH]};
      q_final = sign_q ? -q : q;
   end

`ifdef DIVIDER_REMAINDER_EN
   // remainder restore: the true remainder is in [0, B), so WIDTH bits suffice
   always_comb begin
      p_fixed = p[WIDTH] ? (p[WIDTH-1:0] + b_mag) : p[WIDTH-1:0];
      r_final = sign_r ? -p_fixed : p_fixed;
   end
`endif

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // next-state logic: a start strobe restarts from any state
   always_comb begin
      state_next = state;
      if (ctrl_DIV) begin
         state_next = RUN;
      end else begin
         case (state)
            IDLE: state_next = IDLE;
            RUN: begin
               if (div_zero)                state_next = DONE;
               else if (count == LAST_ITER) state_next = FIX;
            end
            FIX:     state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // output logic
   always_comb begin
      busy = (state != IDLE) && !data_resultRDY;
   end

   // datapath: capture on start, iterate in RUN, finalise in FIX, flag ready in DONE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         p              <= '0;
         q              <= '0;
         b_mag          <= '0;
         count          <= '0;
         sign_q         <= 1'b0;
         div_zero       <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
         a_cap          <= '0;
         sign_r         <= 1'b0;
         data_remainder <= '0;
`endif
      end else if (ctrl_DIV) begin
         p              <= '0;
         q              <= a_mag;
         b_mag          <= b_abs;
         count          <= '0;
         sign_q         <= is_signed && (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
         div_zero       <= (data_operandB == '0);
         data_resultRDY <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
         a_cap          <= data_operandA;
         sign_r         <= is_signed && data_operandA[WIDTH-1];
`endif
      end else begin
         case (state)
            RUN: begin
               if (div_zero) begin
                  data_result    <= '0;
                  data_exception <= 1'b1;
                  data_resultRDY <= 1'b1;
`ifdef DIVIDER_REMAINDER_EN
                  data_remainder <= a_cap;
`endif
               end else begin
                  p     <= p_step;
                  q     <= q_step;
                  count <= count + 1'b1;
               end
            end
            FIX: begin
               data_result    <= q_final;
               data_exception <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
               data_remainder <= r_final;
`endif
            end
            DONE: begin
               if (!data_resultRDY) data_resultRDY <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_nr_param.sv
// tb_divider_nr_param: randomized self-checking bench for divider_nr_param (WIDTH=32).
// Expected quotient/remainder come from plain SystemVerilog arithmetic on 64-bit integers.
// Remainder checks are compiled in only when DIVIDER_REMAINDER_EN is defined.

module tb_divider_nr_param;

   localparam int WIDTH = 32;

   logic             clock;
   logic             reset_n;
   logic             ctrl_DIV;
   logic             is_signed;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
`ifdef DIVIDER_REMAINDER_EN
   logic [WIDTH-1:0] data_remainder;
`endif
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   int tests_run = 0;
   int errors    = 0;

   divider_nr_param #(.WIDTH(WIDTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_DIV       (ctrl_DIV),
      .is_signed      (is_signed),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
`ifdef DIVIDER_REMAINDER_EN
      .data_remainder (data_remainder),
`endif
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   // free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference: integer division as defined for the mode, zero divisor as exception
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [31:0] q, output logic [31:0] r, output logic e);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'd0;
         r = a;
         e = 1'b1;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
         e = 1'b0;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
         e  = 1'b0;
      end
   endfunction

   // present operands and pulse ctrl_DIV for exactly one rising edge
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      is_signed     = sgn;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      is_signed     = 1'(($urandom));
   endtask

   // called just after the start edge: measure latency and compare every output
   task automatic waitResult(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn);
      logic [31:0] eq;
      logic [31:0] er;
      logic        ee;
      int          latency;
      int          exp_lat;
      model(a, b, sgn, eq, er, ee);
      exp_lat = (b == 32'd0) ? 1 : WIDTH + 2;
      checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
      latency = 0;
      while (!data_resultRDY && latency < 64) begin
         @(negedge clock);
         latency++;
      end
      checkOutput({tag, "_latency"}, 64'(latency), 64'(exp_lat));
      checkOutput({tag, "_result"}, 64'(data_result), 64'(eq));
      checkOutput({tag, "_exception"}, 64'(data_exception), 64'(ee));
`ifdef DIVIDER_REMAINDER_EN
      checkOutput({tag, "_remainder"}, 64'(data_remainder), 64'(er));
`endif
      @(negedge clock);
      @(negedge clock);
      checkOutput({tag, "_hold_rdy"}, 64'(data_resultRDY), 64'd1);
      checkOutput({tag, "_hold_result"}, 64'(data_result), 64'(eq));
   endtask

   // main sequence: reset, directed cases, restart, held start, random, mid-run reset
   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      int          rdy_seen;

      reset_n       = 1'b0;
      ctrl_DIV      = 1'b1;
      is_signed     = 1'b0;
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      repeat (3) @(negedge clock);
      checkOutput("reset_result", 64'(data_result), 64'd0);
      checkOutput("reset_exception", 64'(data_exception), 64'd0);
      checkOutput("reset_rdy", 64'(data_resultRDY), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
`ifdef DIVIDER_REMAINDER_EN
      checkOutput("reset_remainder", 64'(data_remainder), 64'd0);
`endif
      ctrl_DIV = 1'b0;
      reset_n  = 1'b1;
      @(negedge clock);
      checkOutput("idle_busy", 64'(busy), 64'd0);

      applyStimulus(32'd100, 32'd7, 1'b0);
      waitResult("u100_7", 32'd100, 32'd7, 1'b0);
      applyStimulus(-32'sd100, 32'd7, 1'b1);
      waitResult("s_m100_7", -32'sd100, 32'd7, 1'b1);
      applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      waitResult("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0);
      waitResult("u_max_2", 32'hFFFF_FFFF, 32'd2, 1'b0);
      applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1);
      waitResult("s_m1_2", 32'hFFFF_FFFF, 32'd2, 1'b1);
      applyStimulus(32'd55, 32'd0, 1'b0);
      waitResult("div_zero", 32'd55, 32'd0, 1'b0);
      applyStimulus(32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
      waitResult("u_big_divisor", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);

      // restart on edge 10 of 100/7 with 81/9; no ready may appear before it
      applyStimulus(32'd100, 32'd7, 1'b0);
      rdy_seen = 0;
      repeat (8) begin
         @(negedge clock);
         if (data_resultRDY) rdy_seen++;
      end
      checkOutput("restart_no_early_rdy", 64'(rdy_seen), 64'd0);
      applyStimulus(32'd81, 32'd9, 1'b0);
      waitResult("restart_81_9", 32'd81, 32'd9, 1'b0);

      // ctrl_DIV held for three edges: only the last captured operands count
      @(negedge clock);
      ctrl_DIV      = 1'b1;
      is_signed     = 1'b0;
      data_operandA = 32'd5;
      data_operandB = 32'd1;
      @(negedge clock);
      data_operandA = 32'd200;
      data_operandB = 32'd3;
      @(negedge clock);
      data_operandA = 32'd77;
      data_operandB = 32'd8;
      @(negedge clock);
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      waitResult("held_start", 32'd77, 32'd8, 1'b0);

      // randomized operands in both modes, with occasional small or zero divisors
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'(($urandom));
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = -32'($urandom_range(1, 15));
            3: ra = 32'h8000_0000;
            default: begin
            end
         endcase
         applyStimulus(ra, rb, rs);
         waitResult($sformatf("rand%0d", i), ra, rb, rs);
      end

      // make sure the result register is nonzero before the asynchronous reset check
      applyStimulus(32'd1000, 32'd3, 1'b0);
      waitResult("pre_reset", 32'd1000, 32'd3, 1'b0);
      applyStimulus(32'd999, 32'd4, 1'b0);
      repeat (5) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_reset_result", 64'(data_result), 64'd0);
      checkOutput("async_reset_rdy", 64'(data_resultRDY), 64'd0);
      checkOutput("async_reset_busy", 64'(busy), 64'd0);
      checkOutput("async_reset_exception", 64'(data_exception), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      rdy_seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY || busy) rdy_seen++;
      end
      checkOutput("post_reset_quiet", 64'(rdy_seen), 64'd0);
      applyStimulus(32'd81, 32'd9, 1'b1);
      waitResult("post_reset_op", 32'd81, 32'd9, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, errors);
      $finish;
   end

endmodule

// File: doc/divider_nr_param.md
DIVIDER_NR_PARAM -- requirements
Module: divider_nr_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ctrl_DIV  input  1  start strobe, sampled on rising clock.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with ctrl_DIV.
REQ-006 SHALL have port data_operandA  input  WIDTH  dividend; sampled with ctrl_DIV.
REQ-007 SHALL have port data_operandB  input  WIDTH  divisor; sampled with ctrl_DIV.
REQ-008 SHALL have port data_result  output  WIDTH  quotient, registered.
REQ-009 SHALL have port data_remainder  output  WIDTH  remainder, registered (present only per REQ-027).
REQ-010 SHALL have port data_exception  output  1  divide-by-zero flag, registered.
REQ-011 SHALL have port data_resultRDY  output  1  result valid, level.
REQ-012 SHALL have port busy  output  1  high while IDLE is not the state and RDY is low.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX, DONE; IDLE->RUN, RUN->FIX, FIX->DONE, DONE->RUN on start, any->RUN on start.
REQ-014 SHALL, on ctrl_DIV=1 at an edge, capture operands and is_signed, load |A| and |B| (absolute only when is_signed=1), clear the iteration counter, clear data_resultRDY, and enter RUN.
REQ-015 SHALL perform one non-restoring iteration per cycle in RUN: shift {P,Q} left 1, P±B by sign of P, Q[0] = ~sign of new P; exactly WIDTH iterations.
REQ-016 SHALL use a (WIDTH+1)-bit partial remainder P so |MIN| (2^(WIDTH-1)) divides without overflow.
REQ-017 SHALL in FIX add B to P if P negative, then apply signs: quotient negated if signA xor signB, remainder takes sign of A (signed mode only).
REQ-018 SHALL assert data_resultRDY exactly WIDTH+2 edges after the start edge and hold it, with data_result/data_remainder/data_exception stable, until the next start or reset.
REQ-019 SHALL on B=0 skip RUN/FIX: next edge enters DONE with data_exception=1, data_result=0, data_remainder=A (latency 1).
REQ-020 SHALL for signed MIN / -1 return data_result=MIN (wrap), data_remainder=0, data_exception=0.
REQ-021 SHALL treat ctrl_DIV during RUN/FIX as a restart: in-flight operation discarded, new operands captured, latency counted from the new edge.
REQ-022 SHALL ignore is_signed and operand changes except at a start edge.
REQ-023 SHALL keep ctrl_DIV held high for k cycles equivalent to a start on the last high cycle.

Reset
REQ-024 SHALL on reset_n=0 immediately force state IDLE, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0, counter=0.
REQ-025 SHALL abort any in-flight operation on reset with no result delivered; first start after reset release behaves per REQ-014.
REQ-026 SHALL not require ctrl_DIV low during reset; a start is honoured only on edges with reset_n=1.

Configuration
REQ-027 SHALL with macro DIVIDER_REMAINDER_EN defined include data_remainder port and remainder sign-correction logic; without it, omit the port and drive no remainder logic, quotient and timing unchanged.

Verification (WIDTH=32)
REQ-028 SHALL cover unsigned 100/7 -> after 34 edges RDY=1, result=14, remainder=2, exception=0.
REQ-029 SHALL cover signed -100/7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); signed 0x80000000/0xFFFFFFFF -> result=0x80000000, remainder=0.
REQ-030 SHALL cover unsigned 0xFFFFFFFF/2 -> result=0x7FFFFFFF, remainder=1; same operands signed -> result=0, remainder=0xFFFFFFFF.
REQ-031 SHALL cover 55/0 -> next edge RDY=1, exception=1, result=0, remainder=55.
REQ-032 SHALL cover restart at edge 10 of 100/7 with 81/9 -> RDY 34 edges after restart, result=9, remainder=0, no RDY pulse in between.
REQ-033 SHALL cover reset_n low mid-RUN -> all outputs 0 asynchronously, busy=0, no RDY until a new start.
